// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the CPU data memory: FSM state encoding and the
// storage geometry.
//   mem_state_t : access FSM states (IDLE, BUSY, DONE)
//   MEM_DEPTH   : number of byte entries in the array
//   DATA_W      : width of one entry / of the data ports
//   ADDR_W      : width of the byte address
// -----------------------------------------------------------------------------
package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int MEM_DEPTH = 256;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;

endpackage

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Byte-addressed 256 x 8 data memory with a fixed multi-cycle access latency.
// busywait stalls the requester (PC freeze) from the request cycle until the
// access has been committed.
//
// Parameters:
//   LATENCY   : cycles busywait stays high per access, request cycle included
//               (legal range 2..15)
// Ports:
//   clock     in   1  rising-edge clock
//   reset     in   1  asynchronous, active-low reset
//   read      in   1  read request, held until busywait falls
//   write     in   1  write request, held until busywait falls (wins over read)
//   address   in   8  byte address
//   writedata in   8  data to store
//   readdata  out  8  data from the last completed read
//   busywait  out  1  stall indication
// -----------------------------------------------------------------------------
module data_memory
  import data_memory_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
);

  // Counter value on which the access is committed.
  localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

  logic [1:0]        rst_sync;
  logic              rst_n;
  mem_state_t        state;
  logic [3:0]        count;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              is_write_q;
  logic              commit;
  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  // Reset synchronizer: assertion is immediate, deassertion is released
  // through two flops so the FSM never leaves reset on an arbitrary phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n  = rst_sync[1];
  assign commit = (state == BUSY) && (count == LAST_COUNT);

  // Access FSM with request latch. The request is captured on the IDLE edge
  // so that later changes of the inputs during BUSY cannot disturb it. DONE
  // always falls back to IDLE, which keeps a request that is still held
  // during DONE from being launched a second time.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= 4'd0;
      addr_q     <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read || write) begin
            addr_q     <= address;
            data_q     <= writedata;
            is_write_q <= write;
            count      <= 4'd1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          count <= count + 4'd1;
          if (commit) begin
            state <= DONE;
          end
        end
        DONE: begin
          count <= 4'd0;
          state <= IDLE;
        end
        default: begin
          count <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage array and read register. Both clear on reset, so a write that
  // was in flight when reset hit is simply lost. readdata only moves on a
  // committed read; writes never touch it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
      readdata <= '0;
    end else if (commit) begin
      if (is_write_q) begin
        mem[addr_q] <= data_q;
      end else begin
        readdata <= mem[addr_q];
      end
    end
  end

  // busywait is decoded combinationally in IDLE so the stall is already
  // visible in the request cycle. It is held low while reset is active.
  always_comb begin
    busywait = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:    busywait = read | write;
        BUSY:    busywait = 1'b1;
        DONE:    busywait = 1'b0;
        default: busywait = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Self-checking bench for data_memory. A plain array plus a "last read" byte
// describes what the memory should hold; every access is checked for its
// stall length, for readdata staying put until the access completes, and for
// the value visible in the DONE cycle.
// -----------------------------------------------------------------------------
module tb_data_memory;

  localparam int LATENCY = 5;

  logic       clock;
  logic       reset;
  logic       read;
  logic       write;
  logic [7:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       busywait;

  logic [7:0] exp_mem [0:255];
  logic [7:0] exp_readdata;

  int checks_done;
  int checks_failed;

  data_memory #(.LATENCY(LATENCY)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .writedata (writedata),
    .readdata  (readdata),
    .busywait  (busywait)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks_done++;
    if (observed !== expected) begin
      checks_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one completed access.
  task automatic model_access(input logic rd, input logic wr,
                              input logic [7:0] addr, input logic [7:0] data);
    if (wr) begin
      exp_mem[addr] = data;
    end else if (rd) begin
      exp_readdata = exp_mem[addr];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 8'h00;
    end
    exp_readdata = 8'h00;
  endtask

  // One full access: raise the request, count the stall cycles while checking
  // that readdata does not move early, then check the DONE cycle and drop the
  // request so nothing is relaunched.
  task automatic apply_stimulus(input string tag, input logic rd, input logic wr,
                                input logic [7:0] addr, input logic [7:0] data);
    int         busy_cnt;
    logic [7:0] rd_before;
    @(negedge clock);
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = data;
    rd_before = exp_readdata;
    #1;
    busy_cnt = 0;
    while (busywait === 1'b1 && busy_cnt < 40) begin
      busy_cnt++;
      check_output({tag, "_hold"}, {24'd0, readdata}, {24'd0, rd_before});
      @(negedge clock);
    end
    check_output({tag, "_busy_cycles"}, busy_cnt, LATENCY);
    model_access(rd, wr, addr, data);
    check_output({tag, "_done_data"}, {24'd0, readdata}, {24'd0, exp_readdata});
    read  = 1'b0;
    write = 1'b0;
    @(negedge clock);
    check_output({tag, "_idle_busy"}, {31'd0, busywait}, 32'd0);
  endtask

  initial begin
    checks_done   = 0;
    checks_failed = 0;
    read      = 1'b0;
    write     = 1'b0;
    address   = 8'h00;
    writedata = 8'h00;
    reset     = 1'b1;
    model_clear();

    // Power-on reset.
    #1 reset = 1'b0;
    #1;
    check_output("reset_readdata", {24'd0, readdata}, 32'd0);
    check_output("reset_busywait", {31'd0, busywait}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Held read: readdata stays 0x00 until commit, then a write leaves it.
    apply_stimulus("prep_33", 1'b0, 1'b1, 8'h40, 8'h33);
    apply_stimulus("read_33", 1'b1, 1'b0, 8'h40, 8'h00);
    apply_stimulus("write_44", 1'b0, 1'b1, 8'h40, 8'h44);
    check_output("rd_after_write", {24'd0, readdata}, 32'h33);

    // Write then read the same address.
    apply_stimulus("write_5a", 1'b0, 1'b1, 8'h10, 8'h5A);
    apply_stimulus("read_5a", 1'b1, 1'b0, 8'h10, 8'h00);
    check_output("read_5a_value", {24'd0, readdata}, 32'h5A);

    // Address extremes and an untouched address.
    apply_stimulus("write_lo", 1'b0, 1'b1, 8'h00, 8'h01);
    apply_stimulus("write_hi", 1'b0, 1'b1, 8'hFF, 8'hFF);
    apply_stimulus("read_lo", 1'b1, 1'b0, 8'h00, 8'h00);
    apply_stimulus("read_hi", 1'b1, 1'b0, 8'hFF, 8'h00);
    apply_stimulus("read_untouched", 1'b1, 1'b0, 8'h80, 8'h00);

    // Simultaneous read and write behaves as a write.
    apply_stimulus("both_77", 1'b1, 1'b1, 8'h20, 8'h77);
    apply_stimulus("read_77", 1'b1, 1'b0, 8'h20, 8'h00);

    // Randomised mix over a small address pool so reads hit written data.
    for (int n = 0; n < 40; n++) begin
      int         op;
      logic [7:0] a;
      logic [7:0] d;
      op = int'($urandom_range(0, 3));
      a  = 8'h60 + 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      case (op)
        0, 1:    apply_stimulus("rand_read", 1'b1, 1'b0, a, d);
        2:       apply_stimulus("rand_write", 1'b0, 1'b1, a, d);
        default: apply_stimulus("rand_both", 1'b1, 1'b1, a, d);
      endcase
    end

    // Make readdata non-zero so the reset clear is observable.
    apply_stimulus("pre_reset_read", 1'b1, 1'b0, 8'h20, 8'h00);

    // Reset in the third busy cycle of a write.
    @(negedge clock);
    write     = 1'b1;
    address   = 8'h05;
    writedata = 8'h99;
    #1;
    check_output("rstw_busy_c0", {31'd0, busywait}, 32'd1);
    @(negedge clock);
    check_output("rstw_busy_c1", {31'd0, busywait}, 32'd1);
    @(negedge clock);
    check_output("rstw_busy_c2", {31'd0, busywait}, 32'd1);
    reset = 1'b0;
    #1;
    model_clear();
    check_output("rstw_busywait", {31'd0, busywait}, 32'd0);
    check_output("rstw_readdata", {24'd0, readdata}, 32'd0);
    @(negedge clock);
    write = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    apply_stimulus("read_after_rst", 1'b1, 1'b0, 8'h05, 8'h00);
    apply_stimulus("read_cleared", 1'b1, 1'b0, 8'h20, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks_done, checks_failed);
    $finish;
  end

endmodule
